// File: rtl/life_pkg.sv
// life_pkg: state encoding and default grid geometry shared by life_gen_engine and pixel_generator.
// LIFE_WRAP_EN adds the two wrap-row read states.
package life_pkg;
  localparam int LIFE_ROW_WIDTH = 2048;
  localparam int LIFE_NUM_ROWS  = 1080;
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] PRIME_RD  = 4'd1;
  localparam logic [3:0] PRIME_CAP = 4'd2;
  localparam logic [3:0] NXT_RD    = 4'd3;
  localparam logic [3:0] NXT_CAP   = 4'd4;
  localparam logic [3:0] COMPUTE   = 4'd5;
  localparam logic [3:0] WRITE     = 4'd6;
  localparam logic [3:0] DONE      = 4'd7;
`ifdef LIFE_WRAP_EN
  localparam logic [3:0] WRAP_RD   = 4'd8;
  localparam logic [3:0] WRAP_CAP  = 4'd9;
`endif
endpackage

// File: rtl/life_row_next.sv
// life_row_next: combinational next-generation row from a three-row window.
// LIFE_WRAP_EN wraps columns; otherwise cells beyond either edge read as dead.
module life_row_next
  import life_pkg::*;
#(
  parameter int ROW_WIDTH = LIFE_ROW_WIDTH
) (
  input  logic [ROW_WIDTH-1:0] i_prev,
  input  logic [ROW_WIDTH-1:0] i_cur,
  input  logic [ROW_WIDTH-1:0] i_nxt,
  output logic [ROW_WIDTH-1:0] o_next
);
  logic [ROW_WIDTH+1:0] w_p, w_c, w_n;
`ifdef LIFE_WRAP_EN
  assign w_p = {i_prev[0], i_prev, i_prev[ROW_WIDTH-1]};
  assign w_c = {i_cur[0],  i_cur,  i_cur[ROW_WIDTH-1]};
  assign w_n = {i_nxt[0],  i_nxt,  i_nxt[ROW_WIDTH-1]};
`else
  assign w_p = {1'b0, i_prev, 1'b0};
  assign w_c = {1'b0, i_cur,  1'b0};
  assign w_n = {1'b0, i_nxt,  1'b0};
`endif
  // extended bit i+1 holds cell i, so cell i's neighbours sit at i, i+1, i+2
  for (genvar i = 0; i < ROW_WIDTH; i++) begin : g_cell
    logic [3:0] w_cnt;
    assign w_cnt = 4'(w_p[i]) + 4'(w_p[i+1]) + 4'(w_p[i+2]) +
                   4'(w_c[i]) + 4'(w_c[i+2]) +
                   4'(w_n[i]) + 4'(w_n[i+1]) + 4'(w_n[i+2]);
    assign o_next[i] = (w_cnt == 4'd3) | (i_cur[i] & (w_cnt == 4'd2));
  end
endmodule

// File: rtl/life_gen_engine.sv
// life_gen_engine: in-place Game-of-Life generation pass over BRAM zero port B with a prev/cur/nxt row window.
// Define LIFE_WRAP_EN for a toroidal grid (extra last-row read plus first_row register).
module life_gen_engine
  import life_pkg::*;
#(
  parameter int ROW_WIDTH  = LIFE_ROW_WIDTH,
  parameter int NUM_ROWS   = LIFE_NUM_ROWS,
  parameter int ADDR_WIDTH = 11,
  parameter int GEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  periph_reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [GEN_WIDTH-1:0]  gen_count,
  output logic [ADDR_WIDTH-1:0] bram_zero_B_addr,
  input  logic [ROW_WIDTH-1:0]  bram_zero_B_requested_data,
  output logic [ROW_WIDTH-1:0]  bram_zero_B_write_data,
  output logic                  bram_zero_B_write_en
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_ROWS - 1);
  logic [3:0] r_state;
  logic [ADDR_WIDTH-1:0] r_row, r_addr;
  logic [ROW_WIDTH-1:0] r_prev, r_cur, r_nxt, r_wdata, w_next, w_tail;
  logic [GEN_WIDTH-1:0] r_gen;
  logic r_busy, r_done, r_we, w_last;
  assign w_last = r_row == LAST;
`ifdef LIFE_WRAP_EN
  localparam logic [3:0] ENTRY = WRAP_RD;
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = LAST;
  logic [ROW_WIDTH-1:0] r_first;
  always_ff @(posedge aclk or posedge periph_reset)
    if (periph_reset) r_first <= '0;
    else if (r_state == PRIME_CAP) r_first <= bram_zero_B_requested_data;
  assign w_tail = r_first;
`else
  localparam logic [3:0] ENTRY = PRIME_RD;
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = '0;
  assign w_tail = '0;
`endif
  life_row_next #(.ROW_WIDTH(ROW_WIDTH)) u_row_next (
    .i_prev(r_prev),
    .i_cur (r_cur),
    .i_nxt (r_nxt),
    .o_next(w_next)
  );
  always_ff @(posedge aclk or posedge periph_reset) begin
    if (periph_reset) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_addr  <= '0;
      r_prev  <= '0;
      r_cur   <= '0;
      r_nxt   <= '0;
      r_wdata <= '0;
      r_gen   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_busy  <= 1'b1;
          r_row   <= '0;
          r_prev  <= '0;
          r_addr  <= START_ADDR;
          r_state <= ENTRY;
        end
`ifdef LIFE_WRAP_EN
        WRAP_RD: r_state <= WRAP_CAP;
        WRAP_CAP: begin
          r_prev  <= bram_zero_B_requested_data;
          r_addr  <= '0;
          r_state <= PRIME_RD;
        end
`endif
        PRIME_RD: r_state <= PRIME_CAP;
        PRIME_CAP: begin
          r_cur   <= bram_zero_B_requested_data;
          r_addr  <= ADDR_WIDTH'(1);
          r_state <= NXT_RD;
        end
        NXT_RD: r_state <= NXT_CAP;
        NXT_CAP: begin
          r_nxt   <= w_last ? w_tail : bram_zero_B_requested_data;
          r_state <= COMPUTE;
        end
        COMPUTE: begin
          r_wdata <= w_next;
          r_addr  <= r_row;
          r_we    <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: if (w_last) begin
          r_gen   <= r_gen + GEN_WIDTH'(1);
          r_done  <= 1'b1;
          r_state <= DONE;
        end else begin
          r_prev  <= r_cur;
          r_cur   <= r_nxt;
          r_row   <= r_row + ADDR_WIDTH'(1);
          r_addr  <= r_row + ADDR_WIDTH'(2);
          r_state <= NXT_RD;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign gen_count              = r_gen;
  assign bram_zero_B_addr       = r_addr;
  assign bram_zero_B_write_data = r_wdata;
  assign bram_zero_B_write_en   = r_we;
endmodule
